// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit beside the EX-stage ALU.
// Shift-add multiplier, restoring divider, and the HI/LO pair.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             cancel_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             dbz;

  logic op_mul, op_div, op_sgn;
  logic op_mthi, op_mtlo;
  logic accept, go, finish;

  assign op_mul  = (op_i == 3'd0) | (op_i == 3'd1);
  assign op_div  = (op_i == 3'd2) | (op_i == 3'd3);
  assign op_sgn  = (op_i == 3'd0) | (op_i == 3'd2);
  assign op_mthi = (op_i == 3'd4);
  assign op_mtlo = (op_i == 3'd5);

  assign accept = (state == IDLE) & start_i & ~cancel_i;
  assign go     = accept & (op_mul | op_div);
  assign finish = (state == FIX) & ~cancel_i;

  assign ready_o = (state == IDLE);
  assign busy_o  = ~ready_o;

  logic [WIDTH-1:0] abs0, abs1;

  assign abs0 = (op_sgn & src0_i[WIDTH-1]) ? -src0_i : src0_i;
  assign abs1 = (op_sgn & src1_i[WIDTH-1]) ? -src1_i : src1_i;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub;

  assign mul_sum = {1'b0, acc_hi}
                 + (acc_lo[0] ? {1'b0, opnd} : '0);
  // 33-bit compare; the kept difference always fits in WIDTH bits
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opnd});
  assign rem_sub = div_sh[WIDTH-1:0] - opnd;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = dbz ? '1 : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go) state_nxt = CALC;
      CALC: begin
        if (cancel_i)
          state_nxt = IDLE;
        else if (cnt == CNTW'(1))
          state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
    end else if (go) begin
      acc_hi  <= '0;
      acc_lo  <= op_div ? abs0 : abs1;
      opnd    <= op_div ? abs1 : abs0;
      cnt     <= CNTW'(WIDTH);
      is_div  <= op_div;
      neg_res <= op_sgn & (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);
      neg_rem <= op_sgn & src0_i[WIDTH-1];
      dbz     <= op_div & (src1_i == '0);
    end else if (state == CALC) begin
      cnt <= cnt - CNTW'(1);
      if (is_div) begin
        acc_hi <= div_ge ? rem_sub : div_sh[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
      dbz_o  <= 1'b0;
    end else begin
      done_o <= finish;
      dbz_o  <= finish & dbz;
      if (accept & op_mthi) hi_o <= src0_i;
      if (accept & op_mtlo) lo_o <= src0_i;
      if (finish) begin
        hi_o <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_o <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule
